// File: rtl/router_pkg.sv
// Shared constants and helpers for the 5-port mesh router.
package router_pkg;

    localparam int unsigned NPORT  = 5;
    localparam int unsigned FLIT_W = 8;

    localparam logic [2:0] PORT_L = 3'd0;
    localparam logic [2:0] PORT_N = 3'd1;
    localparam logic [2:0] PORT_E = 3'd2;
    localparam logic [2:0] PORT_S = 3'd3;
    localparam logic [2:0] PORT_W = 3'd4;

    localparam logic [2:0] SEL_NONE = 3'b111;
    localparam logic [2:0] PTR_RST  = PORT_W;

    typedef logic [2:0] port_idx_t;

    // Port index reached by stepping `step` places after `base`, modulo NPORT.
    function automatic port_idx_t rr_index(input port_idx_t base, input int unsigned step);
        int unsigned s;
        s = (32'(base) + step) % NPORT;
        return s[2:0];
    endfunction

endpackage

// File: rtl/router_sw_alloc_rr_arb5.sv
// Five-request round-robin arbiter: one-hot grant, encoded winner, registered pointer.
module rr_arb5
    import router_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    output logic [NPORT-1:0] gnt,
    output port_idx_t        win_idx,
    output logic             win_valid
);

    port_idx_t ptr_q;
    port_idx_t ptr_d;
    port_idx_t cand;

    always_comb begin
        gnt       = '0;
        win_idx   = SEL_NONE;
        win_valid = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NPORT; k++) begin
            cand = rr_index(ptr_q, k);
            if (!win_valid && req[cand]) begin
                gnt[cand] = 1'b1;
                win_idx   = cand;
                win_valid = 1'b1;
            end
        end
        ptr_d = win_valid ? win_idx : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= PTR_RST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/router_sw_alloc.sv
// Switch allocator and per-output credit controller for the 5-port mesh router.
module router_sw_alloc
    import router_pkg::*;
#(
    parameter int unsigned CREDITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORT-1:0]     req_valid,
    input  logic [3*NPORT-1:0]   req_route,
    input  logic [NPORT-1:0]     ret_out,
    output logic [NPORT-1:0]     grant,
    output logic [3*NPORT-1:0]   xbar_sel,
    output logic [NPORT-1:0]     val_out,
    output logic [NPORT-1:0]     credit_avail,
    output logic                 err
);

    localparam logic [2:0] CRED_MAX = 3'(CREDITS);

    logic [NPORT-1:0]   arb_req [NPORT];
    logic [NPORT-1:0]   arb_gnt [NPORT];
    port_idx_t          arb_win [NPORT];
    logic               arb_hit [NPORT];

    logic [2:0]         credit_q [NPORT];
    logic [2:0]         credit_d [NPORT];
    logic [NPORT-1:0]   val_out_q, val_out_d;
    logic [3*NPORT-1:0] xbar_sel_q, xbar_sel_d;
    logic               err_q, err_d;

    logic [NPORT-1:0]   route_bad;
    port_idx_t          route;

    // Route decode: requests are steered to their output's arbiter only while
    // that output holds credit, and are suppressed entirely during reset.
    always_comb begin
        route_bad = '0;
        route     = '0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            arb_req[o] = '0;
        end
        for (int unsigned i = 0; i < NPORT; i++) begin
            route = req_route[3*i +: 3];
            if (req_valid[i] && (32'(route) >= NPORT)) begin
                route_bad[i] = 1'b1;
            end
            for (int unsigned o = 0; o < NPORT; o++) begin
                if (rst && req_valid[i] && (route == 3'(o)) && (credit_q[o] != '0)) begin
                    arb_req[o][i] = 1'b1;
                end
            end
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
        rr_arb5 u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (arb_req[o]),
            .gnt       (arb_gnt[o]),
            .win_idx   (arb_win[o]),
            .win_valid (arb_hit[o])
        );
    end

    always_comb begin
        grant = '0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            grant = grant | arb_gnt[o];
        end
        grant = grant & {NPORT{rst}};
    end

    always_comb begin
        err_d      = err_q | (|route_bad);
        val_out_d  = '0;
        xbar_sel_d = '1;
        for (int unsigned o = 0; o < NPORT; o++) begin
            credit_d[o]          = credit_q[o];
            val_out_d[o]         = arb_hit[o];
            xbar_sel_d[3*o +: 3] = arb_hit[o] ? arb_win[o] : SEL_NONE;
            if (arb_hit[o] && !ret_out[o]) begin
                credit_d[o] = credit_q[o] - 3'd1;
            end else if (!arb_hit[o] && ret_out[o]) begin
                if (credit_q[o] == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[o] = credit_q[o] + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned o = 0; o < NPORT; o++) begin
                credit_q[o] <= CRED_MAX;
            end
            val_out_q  <= '0;
            xbar_sel_q <= '1;
            err_q      <= 1'b0;
        end else begin
            for (int unsigned o = 0; o < NPORT; o++) begin
                credit_q[o] <= credit_d[o];
            end
            val_out_q  <= val_out_d;
            xbar_sel_q <= xbar_sel_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        credit_avail = '0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            credit_avail[o] = (credit_q[o] != '0);
        end
    end

    assign val_out  = val_out_q;
    assign xbar_sel = xbar_sel_q;
    assign err      = err_q;

endmodule

// File: tb/tb_router_sw_alloc.sv
// Randomized and directed bench for router_sw_alloc against a behavioural allocation model.
module tb_router_sw_alloc;

    localparam int CRED = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req_valid;
    logic [14:0] req_route;
    logic [4:0]  ret_out;
    logic [4:0]  grant;
    logic [14:0] xbar_sel;
    logic [4:0]  val_out;
    logic [4:0]  credit_avail;
    logic        err;

    router_sw_alloc #(.CREDITS(CRED)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_route    (req_route),
        .ret_out      (ret_out),
        .grant        (grant),
        .xbar_sel     (xbar_sel),
        .val_out      (val_out),
        .credit_avail (credit_avail),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the allocator should hold after the last edge.
    int m_credit [5];
    int m_ptr    [5];
    int m_val    [5];
    int m_sel    [5];
    bit m_err;
    int win      [5];

    logic [4:0]  last_grant;
    logic [4:0]  last_val;
    logic [14:0] last_sel;
    logic [4:0]  last_avail;
    logic        last_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int route_of(input int i);
        logic [14:0] r;
        r = req_route;
        return int'(r[3*i +: 3]);
    endfunction

    function automatic logic [14:0] routes(input int a, input int b, input int c, input int d, input int e);
        return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    task automatic m_reset();
        for (int o = 0; o < 5; o++) begin
            m_credit[o] = CRED;
            m_ptr[o]    = 4;
            m_val[o]    = 0;
            m_sel[o]    = 7;
        end
        m_err = 1'b0;
    endtask

    task automatic drive(input logic [4:0] v, input logic [14:0] r, input logic [4:0] ret);
        req_valid = v;
        req_route = r;
        ret_out   = ret;
    endtask

    task automatic cycle(input bit do_chk);
        logic [4:0]  eg;
        logic [4:0]  ev;
        logic [4:0]  ea;
        logic [14:0] es;
        @(negedge clk);
        eg = '0;
        for (int o = 0; o < 5; o++) begin
            win[o] = -1;
            if (rst) begin
                for (int k = 1; k <= 5; k++) begin
                    int i;
                    i = (m_ptr[o] + k) % 5;
                    if (win[o] < 0 && req_valid[i] && route_of(i) == o && m_credit[o] > 0)
                        win[o] = i;
                end
            end
            if (win[o] >= 0) eg[win[o]] = 1'b1;
            ev[o]        = (m_val[o] != 0);
            ea[o]        = (m_credit[o] > 0);
            es[3*o +: 3] = 3'(m_sel[o]);
        end
        last_grant = grant;
        last_val   = val_out;
        last_sel   = xbar_sel;
        last_avail = credit_avail;
        last_err   = err;
        if (do_chk) begin
            check_eq("grant", 32'(grant), 32'(eg));
            check_eq("val_out", 32'(val_out), 32'(ev));
            check_eq("xbar_sel", 32'(xbar_sel), 32'(es));
            check_eq("credit_avail", 32'(credit_avail), 32'(ea));
            check_eq("err", 32'(err), 32'(m_err));
        end
        @(posedge clk);
        if (!rst) begin
            m_reset();
        end else begin
            for (int i = 0; i < 5; i++)
                if (req_valid[i] && route_of(i) > 4) m_err = 1'b1;
            for (int o = 0; o < 5; o++) begin
                bit g;
                g = (win[o] >= 0);
                if (g && !ret_out[o]) m_credit[o]--;
                else if (!g && ret_out[o]) begin
                    if (m_credit[o] == CRED) m_err = 1'b1;
                    else m_credit[o]++;
                end
                if (g) m_ptr[o] = win[o];
                m_val[o] = g ? 1 : 0;
                m_sel[o] = g ? win[o] : 7;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive('0, '0, '0);
        cycle(1);
        rst = 1'b1;
    endtask

    initial begin
        int exp_g [5];
        int exp_s [5];
        exp_g = '{1, 2, 4, 8, 0};
        exp_s = '{7, 0, 1, 2, 3};
        m_reset();
        rst = 1'b0;
        drive(5'($urandom), 15'($urandom), 5'($urandom));
        cycle(0);
        drive(5'($urandom), 15'($urandom), 5'($urandom));
        cycle(1);
        check_eq("rst_grant", 32'(last_grant), 32'h0);
        check_eq("rst_sel", 32'(last_sel), 32'h7FFF);
        check_eq("rst_avail", 32'(last_avail), 32'h1F);
        rst = 1'b1;

        // All inputs contend for E.
        drive(5'h1F, routes(2, 2, 2, 2, 2), '0);
        for (int k = 0; k < 5; k++) begin
            cycle(1);
            check_eq("cont_grant", 32'(last_grant), 32'(exp_g[k]));
            check_eq("cont_sel_e", 32'(last_sel[8:6]), 32'(exp_s[k]));
        end
        check_eq("cont_avail_e", 32'(last_avail[2]), 32'h0);
        drive(5'h1F, routes(2, 2, 2, 2, 2), 5'b00100);
        cycle(1);
        check_eq("cont_ret_same", 32'(last_grant), 32'h0);
        drive(5'h1F, routes(2, 2, 2, 2, 2), '0);
        cycle(1);
        check_eq("cont_ret_w", 32'(last_grant), 32'h10);

        // Non-conflicting permutation.
        do_reset();
        drive(5'h1F, routes(1, 3, 4, 0, 2), '0);
        cycle(1);
        check_eq("par_grant", 32'(last_grant), 32'h1F);
        drive('0, '0, '0);
        cycle(1);
        check_eq("par_val", 32'(last_val), 32'h1F);
        check_eq("par_sel", 32'(last_sel), 32'({3'd2, 3'd1, 3'd4, 3'd0, 3'd3}));

        // Simultaneous grant and return on S (count 3 here).
        drive(5'b00010, routes(0, 3, 0, 0, 0), '0);
        cycle(1);
        cycle(1);
        drive(5'b00010, routes(0, 3, 0, 0, 0), 5'b01000);
        cycle(1);
        check_eq("s_both_grant", 32'(last_grant), 32'h2);
        drive('0, '0, '0);
        cycle(1);
        check_eq("s_both_avail", 32'(last_avail[3]), 32'h1);
        drive(5'b00010, routes(0, 3, 0, 0, 0), '0);
        cycle(1);
        drive(5'b00010, routes(0, 3, 0, 0, 0), 5'b01000);
        cycle(1);
        check_eq("s_zero_ret", 32'(last_grant), 32'h0);
        drive(5'b00010, routes(0, 3, 0, 0, 0), '0);
        cycle(1);
        check_eq("s_after_ret", 32'(last_grant), 32'h2);

        // Error sources.
        do_reset();
        drive('0, '0, 5'b00001);
        cycle(1);
        drive('0, '0, '0);
        cycle(1);
        check_eq("err_ret_sat", 32'(last_err), 32'h1);
        check_eq("err_ret_avail", 32'(last_avail), 32'h1F);
        do_reset();
        drive(5'b10001, routes(1, 0, 0, 0, 5), '0);
        cycle(1);
        check_eq("bad_route_grant", 32'(last_grant), 32'h1);
        cycle(1);
        check_eq("bad_route_err", 32'(last_err), 32'h1);
        check_eq("bad_route_grant2", 32'(last_grant), 32'h1);

        // Reset in the middle of traffic.
        do_reset();
        drive(5'b00001, routes(1, 0, 0, 0, 0), '0);
        for (int k = 0; k < 4; k++) cycle(1);
        drive('0, '0, '0);
        cycle(1);
        check_eq("drain_avail", 32'(last_avail), 32'h1D);
        do_reset();
        drive(5'h1F, routes(1, 1, 1, 1, 1), '0);
        cycle(1);
        check_eq("mid_rst_avail", 32'(last_avail), 32'h1F);
        check_eq("mid_rst_grant", 32'(last_grant), 32'h1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [14:0] r;
            logic [4:0]  ret;
            rst = ($urandom_range(0, 149) != 0);
            for (int i = 0; i < 5; i++) begin
                r[3*i +: 3] = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(5, 7))
                                                            : 3'($urandom_range(0, 4));
                ret[i] = ($urandom_range(0, 2) == 0);
            end
            drive(5'($urandom), r, ret);
            cycle(1);
        end

        rst = 1'b1;
        drive('0, '0, '0);
        cycle(1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
